// File: rtl/sgd_b_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : sgd_b_dispatch
//  Brief    : Splits 2*NUM_OF_BANKS-label memory words into NUM_OF_BANKS-label
//             groups for the loss-stage b FIFO. Per-epoch sample count is
//             honoured: trailing lanes of the last group are zeroed and an
//             unused high half of the last word is dropped.
//  Options  : SGD_B_DISPATCH_STALL_STAT_EN adds the stall_cycles counter port.
//  Revision : 1.0 - initial release
// ============================================================================
module sgd_b_dispatch #(
   parameter int NUM_OF_BANKS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [31:0]                  num_samples,
   input  logic [15:0]                  num_epochs,
   input  logic [64*NUM_OF_BANKS-1:0]   mem_b_data,
   input  logic                         mem_b_valid,
   output logic                         mem_b_ready,
   output logic [32*NUM_OF_BANKS-1:0]   dispatch_axb_b_data,
   output logic                         dispatch_axb_b_wr_en,
   input  logic                         dispatch_axb_b_almost_full,
   output logic                         busy,
   output logic                         done
`ifdef SGD_B_DISPATCH_STALL_STAT_EN
   ,
   output logic [31:0]                  stall_cycles
`endif
);

   localparam int c_LANE_W = 32 * NUM_OF_BANKS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            ns_q, ns_d;
   logic [15:0]            ne_q, ne_d;
   logic [2*c_LANE_W-1:0]  hold_q, hold_d;
   logic                   hold_valid_q, hold_valid_d;
   logic                   half_q, half_d;
   logic [28:0]            out_cnt_q, out_cnt_d;
   logic [15:0]            epoch_cnt_q, epoch_cnt_d;
   logic [c_LANE_W-1:0]    data_q, data_d;
   logic                   wr_en_q, wr_en_d;

   logic                   w_run;
   logic                   w_start_acc;
   logic [32:0]            w_base;
   logic                   w_last_word;
   logic                   w_last_epoch;
   logic                   w_emit;
   logic                   w_final_emit;
   logic                   w_retiring;
   logic                   w_accept;
   logic [c_LANE_W-1:0]    w_sel;

   assign w_run        = (state_q == S_RUN);
   assign w_start_acc  = (state_q == S_IDLE) && start;
   // Index of the first sample carried by the group being emitted.
   assign w_base       = 33'(out_cnt_q) * 33'(NUM_OF_BANKS);
   assign w_last_word  = (w_base + 33'(NUM_OF_BANKS)) >= {1'b0, ns_q};
   assign w_last_epoch = (epoch_cnt_q == (ne_q - 16'd1));
   assign w_emit       = w_run && hold_valid_q && !dispatch_axb_b_almost_full;
   assign w_final_emit = w_emit && w_last_word && w_last_epoch;
   // The held word is consumed after its high half or after an epoch's last group.
   assign w_retiring   = half_q || w_last_word;
   assign mem_b_ready  = w_run && (!hold_valid_q || (w_emit && w_retiring && !w_final_emit));
   assign w_accept     = mem_b_valid && mem_b_ready;
   assign w_sel        = half_q ? hold_q[2*c_LANE_W-1:c_LANE_W] : hold_q[c_LANE_W-1:0];

   assign dispatch_axb_b_data  = data_q;
   assign dispatch_axb_b_wr_en = wr_en_q;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode and job status outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((num_samples != 32'd0) && (num_epochs != 16'd0)) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_final_emit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath next-state: job capture, hold register, counters, output group.
   always_comb begin
      ns_d         = ns_q;
      ne_d         = ne_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      half_d       = half_q;
      out_cnt_d    = out_cnt_q;
      epoch_cnt_d  = epoch_cnt_q;
      data_d       = data_q;
      wr_en_d      = 1'b0;

      if (w_start_acc) begin
         ns_d         = num_samples;
         ne_d         = num_epochs;
         hold_valid_d = 1'b0;
         half_d       = 1'b0;
         out_cnt_d    = 29'd0;
         epoch_cnt_d  = 16'd0;
      end

      if (w_emit) begin
         wr_en_d = 1'b1;
         // Lanes past the epoch's sample count carry no label and go out as zero.
         for (int l = 0; l < NUM_OF_BANKS; l++) begin
            if ((w_base + 33'(l)) < {1'b0, ns_q}) begin
               data_d[l*32 +: 32] = w_sel[l*32 +: 32];
            end else begin
               data_d[l*32 +: 32] = 32'd0;
            end
         end
         if (w_last_word) begin
            // Epoch boundary: any unused high half is dropped.
            out_cnt_d    = 29'd0;
            half_d       = 1'b0;
            hold_valid_d = 1'b0;
            epoch_cnt_d  = epoch_cnt_q + 16'd1;
         end else if (half_q) begin
            out_cnt_d    = out_cnt_q + 29'd1;
            half_d       = 1'b0;
            hold_valid_d = 1'b0;
         end else begin
            out_cnt_d    = out_cnt_q + 29'd1;
            half_d       = 1'b1;
         end
      end

      // A refill landing in the retiring cycle keeps the stream gap-free.
      if (w_accept) begin
         hold_d       = mem_b_data;
         hold_valid_d = 1'b1;
         half_d       = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ns_q         <= 32'd0;
         ne_q         <= 16'd0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         half_q       <= 1'b0;
         out_cnt_q    <= 29'd0;
         epoch_cnt_q  <= 16'd0;
         data_q       <= '0;
         wr_en_q      <= 1'b0;
      end else begin
         ns_q         <= ns_d;
         ne_q         <= ne_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         half_q       <= half_d;
         out_cnt_q    <= out_cnt_d;
         epoch_cnt_q  <= epoch_cnt_d;
         data_q       <= data_d;
         wr_en_q      <= wr_en_d;
      end
   end

`ifdef SGD_B_DISPATCH_STALL_STAT_EN
   logic [31:0] stall_q;

   assign stall_cycles = stall_q;

   // Saturating count of cycles where a ready group is held back by the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 32'd0;
      end else if (w_start_acc) begin
         stall_q <= 32'd0;
      end else if (w_run && hold_valid_q && dispatch_axb_b_almost_full && !(&stall_q)) begin
         stall_q <= stall_q + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sgd_b_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sgd_b_dispatch
//  Brief    : Self-checking bench for sgd_b_dispatch (NUM_OF_BANKS = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sgd_b_dispatch;

   localparam int NB = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic [31:0]       num_samples;
   logic [15:0]       num_epochs;
   logic [64*NB-1:0]  mem_b_data;
   logic              mem_b_valid;
   logic              mem_b_ready;
   logic [32*NB-1:0]  data;
   logic              wr_en;
   logic              af;
   logic              busy;
   logic              done;
`ifdef SGD_B_DISPATCH_STALL_STAT_EN
   logic [31:0]       stall_cycles;
`endif

   sgd_b_dispatch #(.NUM_OF_BANKS(NB)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .start                      (start),
      .num_samples                (num_samples),
      .num_epochs                 (num_epochs),
      .mem_b_data                 (mem_b_data),
      .mem_b_valid                (mem_b_valid),
      .mem_b_ready                (mem_b_ready),
      .dispatch_axb_b_data        (data),
      .dispatch_axb_b_wr_en       (wr_en),
      .dispatch_axb_b_almost_full (af),
      .busy                       (busy),
      .done                       (done)
`ifdef SGD_B_DISPATCH_STALL_STAT_EN
      ,
      .stall_cycles               (stall_cycles)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   int cyc;
   int widx, acc, rdy_cnt;
   bit hs;
   int done_cnt, done_cyc;
   logic [32*NB-1:0] wr_q[$];
   int               wr_c[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever @(posedge clk) cyc++;
   end

   // Label pattern: word w, lane l -> {w[15:0], 8'h5A, l}; never zero.
   function automatic logic [64*NB-1:0] mkword(input int w);
      logic [64*NB-1:0] r;
      for (int l = 0; l < 2*NB; l++) r[l*32 +: 32] = {w[15:0], 8'h5A, 8'(l)};
      return r;
   endfunction

   // Expected group o of epoch e; W groups per epoch, ceil(W/2) words per epoch.
   function automatic logic [32*NB-1:0] exp_out(input int ns, input int w0,
                                                input int W, input int e, input int o);
      logic [64*NB-1:0] wd;
      logic [32*NB-1:0] r;
      int hf;
      wd = mkword(w0 + e*((W+1)/2) + o/2);
      hf = o % 2;
      for (int j = 0; j < NB; j++) begin
         if (o*NB + j < ns) r[j*32 +: 32] = wd[(hf*NB + j)*32 +: 32];
         else               r[j*32 +: 32] = 32'd0;
      end
      return r;
   endfunction

   // Memory source: always valid, advances one word per completed handshake.
   initial begin
      hs = 1'b0; widx = 0; acc = 0; rdy_cnt = 0;
      mem_b_valid = 1'b0; mem_b_data = '0;
      forever begin
         @(negedge clk);
         if (hs) begin
            widx++;
            acc++;
         end
         mem_b_data  = mkword(widx);
         mem_b_valid = 1'b1;
         #3;
         hs = mem_b_valid && mem_b_ready;
         if (mem_b_ready === 1'b1) rdy_cnt++;
      end
   end

   // Output monitor.
   initial begin
      done_cnt = 0; done_cyc = -1;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            wr_q.push_back(data);
            wr_c.push_back(cyc);
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string nm, input logic [32*NB-1:0] got, input logic [32*NB-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic kick(input int ns, input int ne, output int w0, output int q0,
                       output int a0, output int d0, output int r0, output int s);
      step(1);
      w0 = widx; q0 = wr_q.size(); a0 = acc; d0 = done_cnt; r0 = rdy_cnt; s = cyc;
      num_samples = ns;
      num_epochs  = ne[15:0];
      start = 1'b1;
      step(1);
      start = 1'b0;
      num_samples = '1;
      num_epochs  = '1;
   endtask

   task automatic wait_done(input int d0, input string nm);
      int g = 0;
      while (done_cnt == d0 && g < 3000) begin
         step(1);
         g++;
      end
      if (g >= 3000) check({nm, "_done_timeout"}, 0, 1);
   endtask

   task automatic wait_writes(input int q0, input int n, input string nm);
      int g = 0;
      while (wr_q.size() - q0 < n && g < 3000) begin
         step(1);
         g++;
      end
      if (g >= 3000) check({nm, "_write_timeout"}, 0, 1);
   endtask

   task automatic check_stream(input string nm, input int q0, input int ns, input int ne,
                               input int w0, input bit consec);
      int W, n, k, gaps;
      W = (ns + NB - 1) / NB;
      n = (ns == 0 || ne == 0) ? 0 : ne * W;
      if (wr_q.size() - q0 >= n) begin
         for (int e = 0; e < ne; e++)
            for (int o = 0; o < W; o++) begin
               k = q0 + e*W + o;
               check($sformatf("%s_data_e%0d_o%0d", nm, e, o), wr_q[k], exp_out(ns, w0, W, e, o));
            end
         if (consec && n > 1) begin
            gaps = 0;
            for (int i = q0 + 1; i < q0 + n; i++) if (wr_c[i] != wr_c[i-1] + 1) gaps++;
            check({nm, "_gaps"}, gaps, 0);
         end
      end
   endtask

   task automatic run_job(input int ns, input int ne, input int exp_w, input int exp_words);
      int w0, q0, a0, d0, r0, s;
      string nm;
      nm = $sformatf("job_ns%0d_ne%0d", ns, ne);
      kick(ns, ne, w0, q0, a0, d0, r0, s);
      wait_done(d0, nm);
      step(6);
      check({nm, "_writes"}, wr_q.size() - q0, exp_w);
      check({nm, "_words"}, acc - a0, exp_words);
      check({nm, "_dones"}, done_cnt - d0, 1);
      if (exp_w > 0 && wr_q.size() - q0 >= exp_w) begin
         check({nm, "_latency"}, wr_c[q0], s + 3);
         check({nm, "_done_cyc"}, done_cyc, wr_c[q0 + exp_w - 1]);
         check_stream(nm, q0, ns, ne, w0, 1'b1);
      end else if (exp_w == 0) begin
         check({nm, "_done_cyc"}, done_cyc, s + 1);
         check({nm, "_ready_cycles"}, rdy_cnt - r0, 0);
      end
   endtask

   typedef struct {
      int ns;
      int ne;
      int exp_w;
      int exp_words;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int w0, q0, a0, d0, r0, s, rc, nw;
      vecs[0] = '{32, 1, 4, 2};
      vecs[1] = '{20, 2, 6, 4};
      vecs[2] = '{ 0, 1, 0, 0};
      vecs[3] = '{16, 3, 6, 3};
      vecs[4] = '{ 5, 1, 1, 1};
      vecs[5] = '{24, 2, 6, 4};
      vecs[6] = '{ 8, 2, 2, 2};
      vecs[7] = '{12, 0, 0, 0};

      rst = 1'b1; start = 1'b0; num_samples = '0; num_epochs = '0; af = 1'b0;
      step(3);
      check("rst_wr_en", wr_en, 0);
      check("rst_data", data, 0);
      check("rst_ready", mem_b_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      step(2);

      foreach (vecs[i]) run_job(vecs[i].ns, vecs[i].ne, vecs[i].exp_w, vecs[i].exp_words);

      // Back-pressure held for 10 cycles mid-stream.
      kick(64, 1, w0, q0, a0, d0, r0, s);
      wait_writes(q0, 2, "stall");
      af = 1'b1;
      s = cyc;
      step(10);
      af = 1'b0;
      wait_done(d0, "stall");
      step(6);
      check("stall_writes", wr_q.size() - q0, 8);
      check("stall_words", acc - a0, 4);
      nw = 0;
      for (int i = q0; i < wr_q.size(); i++) if (wr_c[i] >= s + 1 && wr_c[i] <= s + 10) nw++;
      check("stall_window_writes", nw, 0);
      check_stream("stall", q0, 64, 1, w0, 1'b0);
`ifdef SGD_B_DISPATCH_STALL_STAT_EN
      check("stall_cycles", stall_cycles, 10);
`endif

      // Reset mid-job, then a fresh 16-sample job.
      kick(32, 1, w0, q0, a0, d0, r0, s);
      wait_writes(q0, 1, "midrst");
      rst = 1'b1;
      rc = cyc;
      step(1);
      rst = 1'b0;
      check("midrst_wr_en", wr_en, 0);
      check("midrst_data", data, 0);
      check("midrst_ready", mem_b_ready, 0);
      check("midrst_busy", busy, 0);
      step(4);
      nw = 0;
      for (int i = q0; i < wr_q.size(); i++) if (wr_c[i] > rc) nw++;
      check("midrst_writes_after_rst", nw, 0);
      run_job(16, 1, 2, 1);

      // Start pulsed again while busy is ignored.
      kick(32, 1, w0, q0, a0, d0, r0, s);
      wait_writes(q0, 2, "rebusy");
      num_samples = 8;
      num_epochs  = 5;
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done(d0, "rebusy");
      step(20);
      check("rebusy_writes", wr_q.size() - q0, 4);
      check("rebusy_dones", done_cnt - d0, 1);
      check("rebusy_busy_after", busy, 0);
      check_stream("rebusy", q0, 32, 1, w0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
